// File: rtl/fp_pkg.sv
// Shared floating-point definitions for the multiplier pipeline.
//   fp_class_e  : operand classification
//   FLAG_*      : bit positions inside the 4-bit exception flag vector
//   RM_*        : rounding-mode encodings
//   fp_qnan()   : canonical quiet NaN for a given exponent/mantissa width
package fp_pkg;

    typedef enum logic [2:0] {ZERO, SUB, NORM, INF, QNAN, SNAN} fp_class_e;

    localparam int FLAG_INVALID   = 3;
    localparam int FLAG_OVERFLOW  = 2;
    localparam int FLAG_UNDERFLOW = 1;
    localparam int FLAG_INEXACT   = 0;

    localparam logic RM_RNE = 1'b0;
    localparam logic RM_RTZ = 1'b1;

    // {0, all-ones exponent, 100..0}, right-aligned in a 64-bit container.
    function automatic logic [63:0] fp_qnan(input int exp_w, input int man_w);
        logic [63:0] exp_ones;
        logic [63:0] quiet_bit;
        exp_ones  = ((64'd1 << exp_w) - 64'd1) << man_w;
        quiet_bit = 64'd1 << (man_w - 1);
        return exp_ones | quiet_bit;
    endfunction

endpackage

// File: rtl/fp_classify.sv
// Operand classifier.
//   op      : in  {exp, man} of one operand (sign not needed here)
//   cls     : out ZERO / SUB / NORM / INF / QNAN / SNAN
//   is_zero : out operand counts as zero once subnormals are flushed
module fp_classify
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 7
) (
    input  logic [EXP_W+MAN_W-1:0] op,
    output fp_class_e              cls,
    output logic                   is_zero
);

    logic [EXP_W-1:0] exp_f;
    logic [MAN_W-1:0] man_f;

    assign exp_f = op[MAN_W +: EXP_W];
    assign man_f = op[MAN_W-1:0];

    always_comb begin
        cls = NORM;
        if (&exp_f) begin
            if (man_f == '0)          cls = INF;
            else if (man_f[MAN_W-1])  cls = QNAN;
            else                      cls = SNAN;
        end else if (exp_f == '0) begin
            cls = (man_f == '0) ? ZERO : SUB;
        end
    end

    assign is_zero = (cls == ZERO) || (cls == SUB);

endmodule

// File: rtl/fp_mult_pipe.sv
// Pipelined floating-point multiplier (default bfloat16), STAGES-cycle latency.
//   clk_i, rst_ni             : clock, asynchronous active-low reset
//   in_valid_i / in_ready_o   : operand handshake
//   a_i, b_i                  : operands {sign, exp, man}
//   rnd_mode_i                : 0 = round-nearest-even, 1 = round-toward-zero
//   tag_i / tag_o             : opaque tag travelling with the operation
//   out_valid_o / out_ready_i : result handshake
//   result_o                  : product
//   flags_o                   : {invalid, overflow, underflow, inexact}
//
// Handshake: a beat transfers on a cycle where valid && ready. Every stage
// keeps a valid bit and loads whenever it is empty or its occupant moves on in
// the same cycle, so bubbles collapse and 1 op/cycle flows with out_ready_i
// high. in_ready_o depends on out_ready_i and stage occupancy only, never on
// in_valid_i. A stalled output holds result/flags/tag stable.
module fp_mult_pipe
    import fp_pkg::*;
#(
    parameter int EXP_W  = 8,
    parameter int MAN_W  = 7,
    parameter int STAGES = 2,
    parameter int TAG_W  = 5
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [EXP_W+MAN_W:0]   a_i,
    input  logic [EXP_W+MAN_W:0]   b_i,
    input  logic                   rnd_mode_i,
    input  logic [TAG_W-1:0]       tag_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [EXP_W+MAN_W:0]   result_o,
    output logic [3:0]             flags_o,
    output logic [TAG_W-1:0]       tag_o
);

    localparam int W    = 1 + EXP_W + MAN_W;
    localparam int PW   = 2 * (MAN_W + 1);
    localparam int XW   = EXP_W + 2;
    localparam int MIDN = (STAGES > 1) ? STAGES - 1 : 1;
    localparam logic [63:0]          QNAN_FULL = fp_qnan(EXP_W, MAN_W);
    localparam logic [W-1:0]         CANON_NAN = QNAN_FULL[W-1:0];
    localparam logic signed [XW-1:0] BIAS_X    = XW'(2**(EXP_W-1) - 1);
    localparam logic signed [XW-1:0] EXP_MAX   = XW'(2**EXP_W - 1);
    localparam logic signed [XW-1:0] EXP_ZERO  = '0;

    // Everything the back end needs: a fully resolved special result, or the
    // sign/exponent sum/raw significand product still to be normalised.
    typedef struct packed {
        logic                   special;
        logic [W-1:0]           spec_res;
        logic [3:0]             spec_flags;
        logic                   sign;
        logic signed [XW-1:0]   exp_sum;
        logic [PW-1:0]          prod;
        logic                   rnd;
        logic [TAG_W-1:0]       tag;
    } mid_t;

    // ---------------- S0: classify, specials, exponent sum, product --------
    fp_class_e cls_a, cls_b;
    logic      zero_a, zero_b;
    logic      nan_a, nan_b, inf_a, inf_b, sign_ab;
    mid_t      mid_d;

    fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_a (
        .op(a_i[W-2:0]), .cls(cls_a), .is_zero(zero_a));
    fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_b (
        .op(b_i[W-2:0]), .cls(cls_b), .is_zero(zero_b));

    assign nan_a   = (cls_a == QNAN) || (cls_a == SNAN);
    assign nan_b   = (cls_b == QNAN) || (cls_b == SNAN);
    assign inf_a   = (cls_a == INF);
    assign inf_b   = (cls_b == INF);
    assign sign_ab = a_i[W-1] ^ b_i[W-1];

    always_comb begin
        mid_d         = '0;
        mid_d.sign    = sign_ab;
        mid_d.rnd     = rnd_mode_i;
        mid_d.tag     = tag_i;
        mid_d.exp_sum = $signed({2'b00, a_i[W-2 -: EXP_W]})
                      + $signed({2'b00, b_i[W-2 -: EXP_W]}) - BIAS_X;
        mid_d.prod    = PW'({1'b1, a_i[MAN_W-1:0]}) * PW'({1'b1, b_i[MAN_W-1:0]});
        if (nan_a || nan_b) begin
            mid_d.special                  = 1'b1;
            mid_d.spec_res                 = CANON_NAN;
            mid_d.spec_flags[FLAG_INVALID] = (cls_a == SNAN) || (cls_b == SNAN);
        end else if ((inf_a && zero_b) || (inf_b && zero_a)) begin
            mid_d.special                  = 1'b1;
            mid_d.spec_res                 = CANON_NAN;
            mid_d.spec_flags[FLAG_INVALID] = 1'b1;
        end else if (inf_a || inf_b) begin
            mid_d.special  = 1'b1;
            mid_d.spec_res = {sign_ab, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (zero_a || zero_b) begin
            // Subnormals are already folded into zero_a/zero_b (flush to zero).
            mid_d.special  = 1'b1;
            mid_d.spec_res = {sign_ab, {(W-1){1'b0}}};
        end
    end

    // ---------------- Pipeline control ------------------------------------
    logic [STAGES-1:0] v_q, vin, en;
    logic              open_slot;
    mid_t              mid_q [MIDN];
    mid_t              pack_in;
    logic [W-1:0]      res_q;
    logic [3:0]        flg_q;
    logic [TAG_W-1:0]  tag_q;

    // Stage k may load when some stage at or after k is empty, or the output
    // is draining; that lets everything upstream of a hole shift forward.
    always_comb begin
        en        = '0;
        vin       = '0;
        open_slot = out_ready_i;
        for (int k = STAGES - 1; k >= 0; k--) begin
            open_slot = open_slot || !v_q[k];
            en[k]     = open_slot;
        end
        vin[0] = in_valid_i;
        for (int k = 1; k < STAGES; k++) vin[k] = v_q[k-1];
    end

    generate
        if (STAGES == 1) begin : g_direct
            assign pack_in = mid_d;
        end else begin : g_piped
            assign pack_in = mid_q[STAGES-2];
        end
    endgenerate

    // ---------------- Last stage: normalise, round, pack -------------------
    logic [PW-2:0]          prod_n;
    logic                   norm, guard_b, sticky, inc;
    logic [MAN_W:0]         man_r;
    logic signed [XW-1:0]   exp_f;
    logic [W-1:0]           res_d;
    logic [3:0]             flg_d;

    always_comb begin
        // Product lies in [1,4): align so the leading one sits just above the
        // stored mantissa field, then the bits below give guard and sticky.
        norm    = pack_in.prod[PW-1];
        prod_n  = norm ? pack_in.prod[PW-2:0] : {pack_in.prod[PW-3:0], 1'b0};
        guard_b = prod_n[PW-2-MAN_W];
        sticky  = |prod_n[PW-3-MAN_W:0];
        inc     = (pack_in.rnd == RM_RNE) && guard_b && (sticky || prod_n[PW-1-MAN_W]);
        man_r   = {1'b0, prod_n[PW-2 -: MAN_W]} + {{MAN_W{1'b0}}, inc};
        // A carry out of the mantissa leaves it all-zero and bumps the exponent.
        exp_f   = pack_in.exp_sum + XW'(norm) + XW'(man_r[MAN_W]);

        res_d = {pack_in.sign, exp_f[EXP_W-1:0], man_r[MAN_W-1:0]};
        flg_d = '0;
        flg_d[FLAG_INEXACT] = guard_b || sticky;
        if (pack_in.special) begin
            res_d = pack_in.spec_res;
            flg_d = pack_in.spec_flags;
        end else if (exp_f >= EXP_MAX) begin
            flg_d[FLAG_OVERFLOW] = 1'b1;
            flg_d[FLAG_INEXACT]  = 1'b1;
            res_d = (pack_in.rnd == RM_RNE)
                  ? {pack_in.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}}
                  : {pack_in.sign, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
        end else if (exp_f <= EXP_ZERO) begin
            flg_d[FLAG_UNDERFLOW] = 1'b1;
            flg_d[FLAG_INEXACT]   = 1'b1;
            res_d = {pack_in.sign, {(W-1){1'b0}}};
        end
    end

    // ---------------- Registers -------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            v_q <= '0;
            for (int k = 0; k < MIDN; k++) mid_q[k] <= '0;
            res_q <= '0;
            flg_q <= '0;
            tag_q <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (en[k]) v_q[k] <= vin[k];
            end
            if (STAGES > 1 && en[0] && in_valid_i) mid_q[0] <= mid_d;
            for (int k = 1; k < STAGES - 1; k++) begin
                if (en[k] && v_q[k-1]) mid_q[k] <= mid_q[k-1];
            end
            if (en[STAGES-1] && vin[STAGES-1]) begin
                res_q <= res_d;
                flg_q <= flg_d;
                tag_q <= pack_in.tag;
            end
        end
    end

    assign in_ready_o  = en[0];
    assign out_valid_o = v_q[STAGES-1];
    assign result_o    = res_q;
    assign flags_o     = flg_q;
    assign tag_o       = tag_q;

endmodule

// File: tb/tb_fp_mult_pipe.sv
// Self-checking bench for fp_mult_pipe (bf16, STAGES=2).
module tb_fp_mult_pipe;

    localparam int STAGES = 2;
    localparam int TAG_W  = 5;
    localparam int W      = 16;
    localparam int SBW    = TAG_W + 4 + W;
    localparam int NVEC   = 21;

    logic              clk, rst_n;
    logic              in_valid, in_ready, rnd, out_valid, out_ready;
    logic [W-1:0]      a, b, result;
    logic [3:0]        flags;
    logic [TAG_W-1:0]  tag, tag_out;

    int checks = 0;
    int errors = 0;
    logic [SBW-1:0] exp_q[$];

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        rnd;
        logic [15:0] res;
        logic [3:0]  flg;
    } vec_t;
    vec_t vecs [NVEC];

    fp_mult_pipe #(.EXP_W(8), .MAN_W(7), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .a_i(a), .b_i(b), .rnd_mode_i(rnd), .tag_i(tag),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .result_o(result), .flags_o(flags), .tag_o(tag_out)
    );

    // ---------------- Clock / watchdog ------------------------------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- Helpers ---------------------------------------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One isolated operation; checks acceptance, latency, result, flags, tag.
    task automatic apply_vec(input int idx);
        int edges;
        a        = vecs[idx].a;
        b        = vecs[idx].b;
        rnd      = vecs[idx].rnd;
        tag      = 5'(idx);
        in_valid = 1'b1;
        out_ready = 1'b1;
        #1;
        check($sformatf("vec%0d in_ready", idx), 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        edges = 1;
        while (!out_valid && edges < 10) begin
            tick();
            edges++;
        end
        check($sformatf("vec%0d latency", idx), 32'(edges), 32'(STAGES));
        check($sformatf("vec%0d result", idx), 32'(result), 32'(vecs[idx].res));
        check($sformatf("vec%0d flags", idx), 32'(flags), 32'(vecs[idx].flg));
        check($sformatf("vec%0d tag", idx), 32'(tag_out), 32'(idx));
        tick();
    endtask

    // Back-to-back stream of 2.0 * b operations; output held off for `stall`
    // cycles. Scoreboard tracks order, tags and occupancy.
    task automatic run_stream(input int n, input int stall, output int cycles);
        int sent, got, occ;
        logic in_fire, out_fire;
        logic [15:0] bv [6];
        bv = '{16'h3F80, 16'h4000, 16'h4040, 16'h4080, 16'h40A0, 16'h40C0};
        exp_q.delete();
        sent = 0; got = 0; occ = 0; cycles = 0;
        rnd = 1'b0;
        while (got < n && cycles < 100) begin
            out_ready = (cycles >= stall);
            in_valid  = (sent < n);
            a   = 16'h4000;
            b   = bv[sent % 6];
            tag = 5'(sent);
            #1;
            check($sformatf("stream in_ready c%0d", cycles), 32'(in_ready),
                  32'((occ < STAGES) || out_ready));
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL stream extra output: got tag %0h expected none", tag_out);
                end else begin
                    check($sformatf("stream out c%0d", cycles),
                          32'({tag_out, flags, result}), 32'(exp_q[0]));
                end
            end
            in_fire  = in_valid && in_ready;
            out_fire = out_valid && out_ready;
            if (out_fire) begin
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                got++;
                occ--;
            end
            if (in_fire) begin
                // Doubling a normal value adds one to its exponent field.
                exp_q.push_back({tag, 4'h0, b + 16'h0080});
                sent++;
                occ++;
            end
            tick();
            cycles++;
        end
        in_valid = 1'b0;
        check("stream delivered", 32'(got), 32'(n));
        check("stream leftover", 32'(exp_q.size()), 32'd0);
    endtask

    // ---------------- Test sequence ---------------------------------------
    initial begin
        int cyc;
        int seen;

        vecs[0]  = '{16'h3FC0, 16'h3FC0, 1'b0, 16'h4010, 4'h0}; // 1.5*1.5
        vecs[1]  = '{16'h3F81, 16'h3FC0, 1'b0, 16'h3FC2, 4'h1}; // tie, odd lsb
        vecs[2]  = '{16'h3F81, 16'h3FC0, 1'b1, 16'h3FC1, 4'h1}; // RTZ
        vecs[3]  = '{16'h7F00, 16'h7F00, 1'b0, 16'h7F80, 4'h5}; // overflow RNE
        vecs[4]  = '{16'h7F00, 16'h7F00, 1'b1, 16'h7F7F, 4'h5}; // overflow RTZ
        vecs[5]  = '{16'h0080, 16'h0080, 1'b0, 16'h0000, 4'h3}; // underflow
        vecs[6]  = '{16'h7F80, 16'h0000, 1'b0, 16'h7FC0, 4'h8}; // inf*0
        vecs[7]  = '{16'hFF80, 16'h4000, 1'b0, 16'hFF80, 4'h0}; // -inf*2
        vecs[8]  = '{16'h7F81, 16'h3F80, 1'b0, 16'h7FC0, 4'h8}; // sNaN
        vecs[9]  = '{16'h4000, 16'hC000, 1'b0, 16'hC080, 4'h0}; // 2*-2
        vecs[10] = '{16'h8000, 16'h3F80, 1'b0, 16'h8000, 4'h0}; // -0*1
        vecs[11] = '{16'h7FC0, 16'h3F80, 1'b0, 16'h7FC0, 4'h0}; // qNaN
        vecs[12] = '{16'h0001, 16'h3F80, 1'b0, 16'h0000, 4'h0}; // subnormal FTZ
        vecs[13] = '{16'h3FB5, 16'h3FB5, 1'b0, 16'h4000, 4'h1}; // round carry
        vecs[14] = '{16'h3FB5, 16'h3FB5, 1'b1, 16'h3FFF, 4'h1}; // same, RTZ
        vecs[15] = '{16'h2000, 16'h2000, 1'b0, 16'h0080, 4'h0}; // min normal
        vecs[16] = '{16'h1F80, 16'h2000, 1'b0, 16'h0000, 4'h3}; // exp 0
        vecs[17] = '{16'h7F00, 16'h4000, 1'b0, 16'h7F80, 4'h5}; // exp 255
        vecs[18] = '{16'hFF80, 16'h0001, 1'b0, 16'h7FC0, 4'h8}; // inf*subnormal
        vecs[19] = '{16'h7F80, 16'hFF80, 1'b0, 16'hFF80, 4'h0}; // inf*-inf
        vecs[20] = '{16'h3F83, 16'h3FC0, 1'b0, 16'h3FC4, 4'h1}; // tie, even lsb

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; rnd = 1'b0; tag = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset result", 32'(result), 32'd0);
        check("reset flags", 32'(flags), 32'd0);
        check("reset tag", 32'(tag_out), 32'd0);
        rst_n = 1'b1;
        tick();
        check("post-reset in_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < NVEC; i++) apply_vec(i);

        // Output held off for 4 cycles: 2 ops fill the pipe, then ready drops.
        run_stream(6, 4, cyc);
        check("backpressure cycles", 32'(cyc), 32'd10);
        // No backpressure: one result per cycle after the initial latency.
        run_stream(6, 0, cyc);
        check("throughput cycles", 32'(cyc), 32'(6 + STAGES));

        // Reset with two operations in flight.
        out_ready = 1'b0;
        rnd = 1'b0;
        a = 16'h3FC0; b = 16'h3FC0; tag = 5'd7; in_valid = 1'b1;
        tick();
        a = 16'h4000; b = 16'h4000; tag = 5'd8;
        tick();
        in_valid = 1'b0;
        check("inflight out_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midreset out_valid", 32'(out_valid), 32'd0);
        check("midreset result", 32'(result), 32'd0);
        check("midreset flags", 32'(flags), 32'd0);
        check("midreset tag", 32'(tag_out), 32'd0);
        @(posedge clk);
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        seen = 0;
        repeat (4) begin
            tick();
            if (out_valid) seen++;
        end
        check("stale after reset", 32'(seen), 32'd0);
        apply_vec(13);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
